// File: rtl/mux2to1_pipe_pkg.sv
// Shared definitions for the mux2to1_pipe registered 2:1 path-select stage.
// Optional parity output is enabled by defining MUX2TO1_PIPE_PARITY_EN.
package mux2to1_pipe_pkg;

  localparam int DATA_W_DEFAULT = 1;
  localparam int DATA_W_MAX     = 64;

  // Select encoding: which input feeds the next load.
  typedef enum logic {
    SEL_I0 = 1'b0,
    SEL_I1 = 1'b1
  } sel_t;

  // Even parity (XOR reduction); callers zero-extend narrower words.
  function automatic logic even_parity(input logic [DATA_W_MAX-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mux2to1_pipe_reg.sv
// Output register of mux2to1_pipe: data, valid and (with
// MUX2TO1_PIPE_PARITY_EN defined) the parity of the loaded word.
// Handshake: a word moves on an edge where valid and ready are both 1; the
// producer holds valid and data stable until that edge, ready never waits on
// valid. Here 'load' is the upstream transfer, y_valid/y_ready the downstream.
module mux2to1_pipe_reg
  import mux2to1_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y,
`ifdef MUX2TO1_PIPE_PARITY_EN
  output logic              y_par,
`endif
  output logic              y_valid
);

  logic [DATA_W-1:0] y_d, y_q;
  logic              valid_d, valid_q;
`ifdef MUX2TO1_PIPE_PARITY_EN
  logic              par_d, par_q;
  logic [DATA_W_MAX-1:0] din_ext;
`endif

  // Next state: load wins (covers consume+load in one cycle), else drain on ready.
  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
`ifdef MUX2TO1_PIPE_PARITY_EN
    par_d   = par_q;
    din_ext = '0;
    din_ext[DATA_W-1:0] = din;
`endif
    if (load) begin
      y_d     = din;
      valid_d = 1'b1;
`ifdef MUX2TO1_PIPE_PARITY_EN
      par_d   = even_parity(din_ext);
`endif
    end else if (y_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register; reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
`ifdef MUX2TO1_PIPE_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
`ifdef MUX2TO1_PIPE_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign y       = y_q;
  assign y_valid = valid_q;
`ifdef MUX2TO1_PIPE_PARITY_EN
  assign y_par   = par_q;
`endif

endmodule

// File: rtl/mux2to1_pipe.sv
// mux2to1_pipe: registered 2:1 multiplexer with valid/ready on I0, I1 and Y.
// Define MUX2TO1_PIPE_PARITY_EN to add the Y_par output.
// Handshake: a word transfers on an edge where its valid and ready are both 1;
// readies depend only on S, Y_valid, Y_ready and rst_n, never on input valids.
module mux2to1_pipe
  import mux2to1_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] I0,
  input  logic              I0_valid,
  output logic              I0_ready,
  input  logic [DATA_W-1:0] I1,
  input  logic              I1_valid,
  output logic              I1_ready,
  input  logic              S,
  output logic [DATA_W-1:0] Y,
`ifdef MUX2TO1_PIPE_PARITY_EN
  output logic              Y_par,
`endif
  output logic              Y_valid,
  input  logic              Y_ready
);

  sel_t              sel;
  logic              free;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              load;

  assign sel = sel_t'(S);

  // Select path; case on the known select keeps an X on the unselected data out.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    case (sel)
      SEL_I0: begin
        sel_valid = I0_valid;
        sel_data  = I0;
      end
      SEL_I1: begin
        sel_valid = I1_valid;
        sel_data  = I1;
      end
      default: begin
        sel_valid = 1'b0;
        sel_data  = '0;
      end
    endcase
  end

  // Readiness: only the selected input may transfer, and only when Y can take a word.
  always_comb begin
    free     = !Y_valid || Y_ready;
    I0_ready = rst_n && free && (sel == SEL_I0);
    I1_ready = rst_n && free && (sel == SEL_I1);
    load     = free && sel_valid;
  end

  mux2to1_pipe_reg #(
    .DATA_W(DATA_W)
  ) u_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .din     (sel_data),
    .y_ready (Y_ready),
    .y       (Y),
`ifdef MUX2TO1_PIPE_PARITY_EN
    .y_par   (Y_par),
`endif
    .y_valid (Y_valid)
  );

endmodule

// File: tb/tb_mux2to1_pipe.sv
// Self-checking bench for mux2to1_pipe (DATA_W=8). Exercises Y_par when
// MUX2TO1_PIPE_PARITY_EN is defined.
module tb_mux2to1_pipe;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] I0, I1, Y;
  logic         I0_valid, I0_ready, I1_valid, I1_ready;
  logic         S, Y_valid, Y_ready;
`ifdef MUX2TO1_PIPE_PARITY_EN
  logic         Y_par;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: words sitting in the output stage (at most one) plus the
  // last word ever loaded, which Y keeps showing after it drains.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_y;
  logic         last_par;

  mux2to1_pipe #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .I0(I0), .I0_valid(I0_valid), .I0_ready(I0_ready),
    .I1(I1), .I1_valid(I1_valid), .I1_ready(I1_ready),
    .S(S), .Y(Y),
`ifdef MUX2TO1_PIPE_PARITY_EN
    .Y_par(Y_par),
`endif
    .Y_valid(Y_valid), .Y_ready(Y_ready)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".y_valid"}, 64'(Y_valid), 64'(exp_q.size() != 0));
    check({tag, ".y"}, 64'(Y), 64'(exp_q.size() != 0 ? exp_q[0] : last_y));
`ifdef MUX2TO1_PIPE_PARITY_EN
    check({tag, ".y_par"}, 64'(Y_par), 64'(last_par));
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_y   = '0;
    last_par = 1'b0;
  endtask

  // One clock of traffic: drive at negedge, check readies, then outputs after the edge.
  task automatic step(input string tag, input logic [W-1:0] i0, input logic [W-1:0] i1,
                      input logic s, input logic v0, input logic v1, input logic yr);
    bit free, take, acc;
    logic [W-1:0] w;
    @(negedge clk);
    I0 = i0; I1 = i1; S = s; I0_valid = v0; I1_valid = v1; Y_ready = yr;
    #1;
    free = (exp_q.size() == 0) || yr;
    take = (exp_q.size() != 0) && yr;
    acc  = free && (s ? v1 : v0);
    check({tag, ".i0_ready"}, 64'(I0_ready), 64'(free && !s));
    check({tag, ".i1_ready"}, 64'(I1_ready), 64'(free && s));
    @(posedge clk);
    #1;
    if (take) void'(exp_q.pop_front());
    if (acc) begin
      w = s ? i1 : i0;
      exp_q.push_back(w);
      last_y   = w;
      last_par = ^w;
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [2:0] tt_pat [8];
    tt_pat = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};

    rst_n = 1'b0; I0 = '0; I1 = '0; S = 1'b0;
    I0_valid = 1'b0; I1_valid = 1'b0; Y_ready = 1'b1;
    model_reset();
    #3;
    check("reset.i0_ready", 64'(I0_ready), 64'(0));
    check("reset.i1_ready", 64'(I1_ready), 64'(0));
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Truth table sweep: bit2=I0, bit1=I1, bit0=S.
    for (int i = 0; i < 8; i++) begin
      step("truth", W'(tt_pat[i][2]), W'(tt_pat[i][1]), tt_pat[i][0], 1'b1, 1'b1, 1'b1);
    end

    // Asynchronous reset between edges with a word held.
    step("pre_rst", 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    I0 = 8'h01; S = 1'b0; I0_valid = 1'b1; I1_valid = 1'b0; Y_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.i0_ready", 64'(I0_ready), 64'(0));
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    check("post_rst.y_is_1", 64'(Y), 64'h1);

    // Back-pressure.
    step("bp_load", 8'h00, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("bp_hold", 8'h00, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    check("bp.y_held", 64'(Y), 64'hA5);
    step("bp_release", 8'h00, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    check("bp.y_new", 64'(Y), 64'h3C);

    // Unselected input held off, then selected.
    step("holdoff", 8'h00, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    step("holdoff_sel", 8'h00, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1);
    check("holdoff.y", 64'(Y), 64'h11);

    // X on the unselected data input.
    step("x_i1", 8'h66, 'x, 1'b0, 1'b1, 1'b1, 1'b1);
    step("x_i0", 'x, 8'h99, 1'b1, 1'b1, 1'b1, 1'b1);

    // Streaming with S toggling.
    for (int i = 0; i < 8; i++) begin
      step("stream", W'(8'h01 + i), W'(8'h81 + i), 1'(i & 1), 1'b1, 1'b1, 1'b1);
    end

`ifdef MUX2TO1_PIPE_PARITY_EN
    step("par7", 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    check("par7.y_par", 64'(Y_par), 64'h1);
    step("par3", 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    check("par3.y_par", 64'(Y_par), 64'h0);
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2to1_pipe.md
Name: mux2to1_pipe

Overview:
- Registered 2:1 data multiplexer with valid/ready flow control on both inputs and the output.
- Selects input I0 when S=0 and I1 when S=1, then presents the chosen word on Y one clock later.
- Used as a generic path-select stage between streaming producers and a single consumer.
- With DATA_W=1 and always-ready/valid handshakes it reduces to the classic truth table, delayed by one clock: Y = S ? I1 : I0.

Parameters:
- DATA_W, 1, width of I0, I1 and Y in bits (legal range 1..64).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, release is synchronous to clk.
- I0  input  DATA_W  data input 0.
- I0_valid  input  1  I0 holds a valid word.
- I0_ready  output  1  stage accepts I0 this cycle.
- I1  input  DATA_W  data input 1.
- I1_valid  input  1  I1 holds a valid word.
- I1_ready  output  1  stage accepts I1 this cycle.
- S  input  1  select: 0 = I0, 1 = I1; sampled every cycle.
- Y  output  DATA_W  registered selected data.
- Y_valid  output  1  Y holds a valid word.
- Y_ready  input  1  consumer accepts Y this cycle.

Behaviour:
- Reset (rst_n=0, any time, including mid-transfer):
  - Y=0 and Y_valid=0 immediately.
  - Any held word is discarded.
  - I0_ready and I1_ready are driven 0 while rst_n=0.
- Stage is free when Y_valid=0 or Y_ready=1. Define load = free AND selected_valid, where selected_valid = S ? I1_valid : I0_valid.
- Ready generation (combinational from S, Y_valid, Y_ready; never depends on I0_valid/I1_valid):
  - I0_ready = free AND (S==0).
  - I1_ready = free AND (S==1).
  - The unselected input's ready is always 0, so its valid word is held off, never dropped.
- On the clock edge:
  - If load: Y <= selected data, Y_valid <= 1.
  - Else if Y_ready=1: Y_valid <= 0, and Y keeps its last value.
  - Else: hold Y and Y_valid.
- Latency: exactly 1 cycle from accepted input to Y_valid.
- Throughput: 1 word/cycle when Y_ready is held high.
- Back-pressure:
  - Y_valid=1 and Y_ready=0 → Y and Y_valid stable; both input readies 0.
- Simultaneous events:
  - Y consumed and new word loaded in the same cycle → Y_valid stays 1, Y takes the new word.
  - Both inputs valid → only the S-selected one transfers.
- S may change on any cycle. It has no effect on a word already in Y; it affects only the next load.
- No combinational path from I0/I1 to Y.
- X on the unselected data input must not propagate to Y.

Optional Feature:
- Macro: MUX2TO1_PIPE_PARITY_EN.
- When defined:
  - Extra output Y_par (1 bit) = even parity (XOR reduction) of the word loaded into Y.
  - Registered alongside Y and updated only on load.
  - Reset value 0.
- When undefined: port Y_par is absent; no parity logic is generated.

Decomposition:
- Package mux2to1_pipe_pkg:
  - Constant DATA_W_DEFAULT = 1.
  - Typedef sel_t (1-bit enum: SEL_I0=0, SEL_I1=1).
  - Function for the parity computation.
- Natural sub-module mux2to1_pipe_reg:
  - The valid/ready output register (data, valid, optional parity).
  - Instantiated once by the top, which holds the select/ready logic.

Test Plan:
- Truth table, DATA_W=1, all valids and Y_ready=1: sweep (I0,I1,S) over 000,010,100,110,001,011,101,111 at 10 ns per step → Y one cycle later = 0,0,1,1,0,1,0,1 respectively; Y_valid=1.
- Reset: drive I0=1, S=0, I0_valid=1, then assert rst_n=0 between clock edges → Y=0 and Y_valid=0 at once; after release, the first edge loads Y=1.
- Back-pressure, DATA_W=8: load I1=0xA5 with S=1, then Y_ready=0 for 3 cycles while I1=0x3C is valid → Y stays 0xA5, I1_ready=0; raising Y_ready gives Y=0x3C on the next edge.
- Unselected hold-off: S=0, I0_valid=0, I1_valid=1, I1=0x11 → I1_ready=0 and Y_valid goes 0. Switch S=1 → I1_ready=1 and Y=0x11 next cycle.
- Streaming: Y_ready=1, S toggling each cycle, I0=0x01,0x02,... and I1=0x81,0x82,... → Y alternates between the I0 and I1 streams with 1-cycle latency and no bubbles.
- Parity (MUX2TO1_PIPE_PARITY_EN defined): load 0x07 → Y_par=1; load 0x03 → Y_par=0.
